fcore_dma_readback_sequencer: RTL



---
 rtl/fcore_readback_pkg.sv | 18 +
 rtl/readback_output_buffer.sv | 63 ++++++
 rtl/fcore_dma_readback_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fcore_readback_pkg.sv
// Shared types for the fCore DMA readback sequencer: FSM state encoding and
// the channel counter width helper.
package fcore_readback_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        REQUEST       = 3'd1,
        WAIT_RESPONSE = 3'd2,
        OUTPUT        = 3'd3,
        FINISH        = 3'd4
    } state_e;

    // Wide enough to hold MAX_CHANNELS itself, not just MAX_CHANNELS-1.
    function automatic int ch_width(input int max_channels);
        return $clog2(max_channels) + 1;
    endfunction

endpackage

// File: rtl/readback_output_buffer.sv
// Single-entry AXI-stream holding register: a load captures data/dest/last and
// raises valid, which stays up with stable payload until the consumer accepts it.
module readback_output_buffer #(
    parameter int DATA_WIDTH = 20,
    parameter int DEST_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [DEST_WIDTH-1:0] load_dest,
    input  logic                  load_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DEST_WIDTH-1:0] out_dest,
    output logic                  out_last
);

    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic [DEST_WIDTH-1:0] dest_d, dest_q;
    logic                  last_d, last_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        dest_d  = dest_q;
        last_d  = last_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            dest_d  = load_dest;
            last_d  = load_last;
        end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: payload registers are cleared too, so the bus reads all-zero out of reset.
            valid_q <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_dest  = dest_q;
    assign out_last  = last_q;

endmodule

// File: rtl/fcore_dma_readback_sequencer.sv
// On a core-done trigger, reads endpoint registers 1..n_channels one at a time
// and forwards each response as an AXI-stream beat tagged with dest and last.
module fcore_dma_readback_sequencer
    import fcore_readback_pkg::*;
#(
    parameter int DATAPATH_WIDTH   = 20,
    parameter int MAX_CHANNELS     = 16,
    parameter int DEST_BASE        = 0,
    parameter int RESPONSE_TIMEOUT = 15
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [$clog2(MAX_CHANNELS):0]  n_channels,
    output logic                           read_request_valid,
    input  logic                           read_request_ready,
    output logic [31:0]                    read_request_data,
    input  logic                           read_response_valid,
    output logic                           read_response_ready,
    input  logic [DATAPATH_WIDTH-1:0]      read_response_data,
    output logic                           data_out_valid,
    input  logic                           data_out_ready,
    output logic [DATAPATH_WIDTH-1:0]      data_out_data,
    output logic [31:0]                    data_out_dest,
    output logic                           data_out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           timeout_error,
    output logic                           start_overrun
);

    localparam int            CW         = ch_width(MAX_CHANNELS);
    localparam int            TW         = $clog2(RESPONSE_TIMEOUT + 1);
    localparam logic [CW-1:0] MAX_CH     = CW'(MAX_CHANNELS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(RESPONSE_TIMEOUT - 1);

    state_e        state_d, state_q;
    logic [CW-1:0] ch_d, ch_q;
    logic [CW-1:0] n_eff_d, n_eff_q;
    logic [TW-1:0] timer_d, timer_q;
    logic          done_d, done_q;
    logic          timeout_d, timeout_q;
    logic          overrun_d, overrun_q;
    logic [CW-1:0] n_clamped;
    logic          buf_load;

    assign n_clamped = (n_channels > MAX_CH) ? MAX_CH : n_channels;

    always_comb begin
        state_d            = state_q;
        ch_d               = ch_q;
        n_eff_d            = n_eff_q;
        timer_d            = timer_q;
        timeout_d          = timeout_q;
        overrun_d          = overrun_q | (start && (state_q != IDLE));
        done_d             = (state_q == FINISH);
        buf_load           = 1'b0;
        read_request_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_eff_d = n_clamped;
                    ch_d    = CW'(1);
                    state_d = (n_clamped == '0) ? FINISH : REQUEST;
                end
            end
            REQUEST: begin
                read_request_valid = 1'b1;
                if (read_request_ready) begin
                    timer_d = '0;
                    state_d = WAIT_RESPONSE;
                end
            end
            WAIT_RESPONSE: begin
                // A response arriving on the final timeout cycle still wins.
                if (read_response_valid) begin
                    buf_load = 1'b1;
                    state_d  = OUTPUT;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            OUTPUT: begin
                if (data_out_valid && data_out_ready) begin
                    if (data_out_last) begin
                        state_d = FINISH;
                    end else begin
                        ch_d    = ch_q + CW'(1);
                        state_d = REQUEST;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            n_eff_q   <= '0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            n_eff_q   <= n_eff_d;
            timer_q   <= timer_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    readback_output_buffer #(
        .DATA_WIDTH (DATAPATH_WIDTH),
        .DEST_WIDTH (32)
    ) u_output_buffer (
        .clock     (clock),
        .reset     (reset),
        .load      (buf_load),
        .load_data (read_response_data),
        .load_dest (32'(ch_q) + 32'(DEST_BASE)),
        .load_last (ch_q == n_eff_q),
        .out_valid (data_out_valid),
        .out_ready (data_out_ready),
        .out_data  (data_out_data),
        .out_dest  (data_out_dest),
        .out_last  (data_out_last)
    );

    // The endpoint cannot be stalled; stray responses are simply not loaded.
    assign read_response_ready = 1'b1;
    assign read_request_data   = read_request_valid ? 32'(ch_q) : 32'd0;
    assign busy                = (state_q != IDLE);
    assign done                = done_q;
    assign timeout_error       = timeout_q;
    assign start_overrun       = overrun_q;

endmodule
